ram_arbiter: RTL and testbench

//  Two-master arbiter sharing one single-port data RAM: m0 = instruction fetch, m1 = load/store unit.

---
 rtl/ram_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of one single-port data RAM (m0 = fetch,
// m1 = load/store), one transaction outstanding, with response watchdog.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mN_addr_i/data_i/sel_i/we_i master N request fields (N = 0, 1)
//   mN_req_valid_i/req_ready_o  master N request handshake
//   mN_rsp_valid_o/rsp_ready_i  master N response handshake
//   mN_data_o, mN_err_o         master N read data, timeout error flag
//   s_addr_o/data_o/sel_o/we_o  muxed request fields to the RAM
//   s_req_valid_o/req_ready_i   RAM request handshake
//   s_rsp_valid_i/rsp_ready_o   RAM response handshake
//   s_data_i                    RAM read data
//
// Parameters:
//   RR       1: round-robin on a tie, 0: fixed priority (m0 wins)
//   TIMEOUT  cycles waited for a response before an error; 0 = off

module ram_arbiter #(
  parameter bit          RR      = 1'b1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_req_valid_i,
  output logic        m0_req_ready_o,
  output logic        m0_rsp_valid_o,
  input  logic        m0_rsp_ready_i,
  output logic [31:0] m0_data_o,
  output logic        m0_err_o,

  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_req_valid_i,
  output logic        m1_req_ready_o,
  output logic        m1_rsp_valid_o,
  input  logic        m1_rsp_ready_i,
  output logic [31:0] m1_data_o,
  output logic        m1_err_o,

  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_req_valid_o,
  input  logic        s_req_ready_i,
  input  logic        s_rsp_valid_i,
  output logic        s_rsp_ready_o,
  input  logic [31:0] s_data_i
);

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RSP  = 2'd1,
    ERR  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        stale_q, stale_d;
  logic [15:0] cnt_q, cnt_d;

  logic win;
  logic issue;
  logic in_rsp;
  logic in_err;
  logic own_rdy;
  logic rsp_v;
  logic fwd;

  // On a tie m1 wins only under round-robin when m0 had the last grant.
  assign win = m1_req_valid_i &
               (~m0_req_valid_i | (RR & ~last_q));

  assign issue = ~rst & (state_q == IDLE) & ~stale_q &
                 (m0_req_valid_i | m1_req_valid_i);

  assign in_rsp  = ~rst & (state_q == RSP);
  assign in_err  = ~rst & (state_q == ERR);
  assign own_rdy = owner_q ? m1_rsp_ready_i : m0_rsp_ready_i;

  // Forwarded RAM beat, or the synthesised error beat.
  assign fwd   = in_rsp & s_rsp_valid_i;
  assign rsp_v = fwd | in_err;

  always_comb begin
    s_req_valid_o = issue;
    s_addr_o      = '0;
    s_data_o      = '0;
    s_sel_o       = '0;
    s_we_o        = 1'b0;
    if (issue) begin
      unique case (1'b1)
        win: begin
          s_addr_o = m1_addr_i;
          s_data_o = m1_data_i;
          s_sel_o  = m1_sel_i;
          s_we_o   = m1_we_i;
        end
        default: begin
          s_addr_o = m0_addr_i;
          s_data_o = m0_data_i;
          s_sel_o  = m0_sel_i;
          s_we_o   = m0_we_i;
        end
      endcase
    end
  end

  assign m0_req_ready_o = issue & ~win & s_req_ready_i;
  assign m1_req_ready_o = issue &  win & s_req_ready_i;

  assign m0_rsp_valid_o = rsp_v & ~owner_q;
  assign m1_rsp_valid_o = rsp_v &  owner_q;

  assign m0_err_o = in_err & ~owner_q;
  assign m1_err_o = in_err &  owner_q;

  assign m0_data_o = (fwd & ~owner_q) ? s_data_i : 32'h0;
  assign m1_data_o = (fwd &  owner_q) ? s_data_i : 32'h0;

  // A stale response is always swallowed, in ERR or after it.
  assign s_rsp_ready_o = (in_rsp & own_rdy) | in_err |
                         (~rst & (state_q == IDLE) & stale_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    stale_d = stale_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (stale_q) begin
          if (s_rsp_valid_i) begin
            stale_d = 1'b0;
          end
        end else if (issue && s_req_ready_i) begin
          owner_d = win;
          last_d  = win;
          cnt_d   = '0;
          state_d = RSP;
        end
      end
      RSP: begin
        if (s_rsp_valid_i) begin
          // Counter frozen while the owner back-pressures.
          if (own_rdy) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (TO_EN && (cnt_q == TO_LAST)) begin
            state_d = ERR;
            stale_d = 1'b1;
          end
        end
      end
      ERR: begin
        if (s_rsp_valid_i) begin
          stale_d = 1'b0;
        end
        if (own_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      stale_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      stale_q <= stale_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one round-robin and one fixed-priority instance
// on shared stimulus, a cycle model, and directed scenarios.

module tb_ram_arbiter;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;

  logic [1:0][31:0] m_adr;
  logic [1:0][31:0] m_wd;
  logic [1:0][3:0]  m_sel;
  logic [1:0]       m_we;
  logic [1:0]       m_vld;
  logic [1:0]       m_rrdy;
  logic             s_qrdy;
  logic             s_rv;
  logic [31:0]      s_rd;

  wire [1:0][1:0]       q_rdy;
  wire [1:0][1:0]       r_vld;
  wire [1:0][1:0]       r_err;
  wire [1:0][1:0][31:0] r_dat;
  wire [1:0][31:0]      s_adr;
  wire [1:0][31:0]      s_dat;
  wire [1:0][3:0]       s_sel;
  wire [1:0]            s_we;
  wire [1:0]            s_vld;
  wire [1:0]            s_rrdy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_arbiter #(
      .RR(g == 0),
      .TIMEOUT(TMO)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .m0_addr_i(m_adr[0]),
      .m0_data_i(m_wd[0]),
      .m0_sel_i(m_sel[0]),
      .m0_we_i(m_we[0]),
      .m0_req_valid_i(m_vld[0]),
      .m0_req_ready_o(q_rdy[g][0]),
      .m0_rsp_valid_o(r_vld[g][0]),
      .m0_rsp_ready_i(m_rrdy[0]),
      .m0_data_o(r_dat[g][0]),
      .m0_err_o(r_err[g][0]),
      .m1_addr_i(m_adr[1]),
      .m1_data_i(m_wd[1]),
      .m1_sel_i(m_sel[1]),
      .m1_we_i(m_we[1]),
      .m1_req_valid_i(m_vld[1]),
      .m1_req_ready_o(q_rdy[g][1]),
      .m1_rsp_valid_o(r_vld[g][1]),
      .m1_rsp_ready_i(m_rrdy[1]),
      .m1_data_o(r_dat[g][1]),
      .m1_err_o(r_err[g][1]),
      .s_addr_o(s_adr[g]),
      .s_data_o(s_dat[g]),
      .s_sel_o(s_sel[g]),
      .s_we_o(s_we[g]),
      .s_req_valid_o(s_vld[g]),
      .s_req_ready_i(s_qrdy),
      .s_rsp_valid_i(s_rv),
      .s_rsp_ready_o(s_rrdy[g]),
      .s_data_i(s_rd)
    );
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Transaction-level view: waiting on the RAM, error pending,
  // stale response to drain, and how long we have waited.
  typedef struct {
    bit busy;
    bit fail;
    bit who;
    bit prev;
    bit drain;
    int waited;
  } mst_t;

  typedef struct {
    bit [1:0]       qrdy;
    bit [1:0]       rvld;
    bit [1:0]       rerr;
    bit [1:0][31:0] rdat;
    bit             svld;
    bit             srrdy;
    bit             win;
  } mout_t;

  mst_t  ms [2];
  mout_t po, uo;
  mst_t  pn, un;

  function automatic void predict(input bit rr, input mst_t s,
                                  output mout_t o, output mst_t n);
    bit w;
    o.qrdy  = '0;
    o.rvld  = '0;
    o.rerr  = '0;
    o.rdat  = '0;
    o.svld  = 1'b0;
    o.srrdy = 1'b0;
    o.win   = 1'b0;
    n = s;
    if (rst) begin
      n.busy = 0; n.fail = 0; n.drain = 0;
      n.prev = 1; n.waited = 0;
      return;
    end
    if (s.fail) begin
      o.rvld[s.who] = 1'b1;
      o.rerr[s.who] = 1'b1;
      o.srrdy = 1'b1;
      if (s_rv) n.drain = 0;
      if (m_rrdy[s.who]) n.fail = 0;
    end else if (s.busy) begin
      o.rvld[s.who] = s_rv;
      if (s_rv) o.rdat[s.who] = s_rd;
      o.srrdy = m_rrdy[s.who];
      if (s_rv) begin
        if (m_rrdy[s.who]) n.busy = 0;
      end else begin
        n.waited = s.waited + 1;
        if (TMO != 0 && n.waited >= TMO) begin
          n.busy = 0; n.fail = 1; n.drain = 1;
        end
      end
    end else if (s.drain) begin
      o.srrdy = 1'b1;
      if (s_rv) n.drain = 0;
    end else if (m_vld != 2'b00) begin
      if (m_vld == 2'b11) w = rr ? !s.prev : 1'b0;
      else w = m_vld[1];
      o.svld = 1'b1;
      o.win = w;
      o.qrdy[w] = s_qrdy;
      if (s_qrdy) begin
        n.busy = 1; n.who = w; n.prev = w; n.waited = 0;
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      predict(g == 0, ms[g], uo, un);
      ms[g] <= un;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 2; g++) begin
        predict(g == 0, ms[g], po, pn);
        chk($sformatf("d%0d_qrdy", g), 32'(q_rdy[g]), 32'(po.qrdy));
        chk($sformatf("d%0d_rvld", g), 32'(r_vld[g]), 32'(po.rvld));
        chk($sformatf("d%0d_rerr", g), 32'(r_err[g]), 32'(po.rerr));
        chk($sformatf("d%0d_svld", g), 32'(s_vld[g]), 32'(po.svld));
        chk($sformatf("d%0d_srrdy", g), 32'(s_rrdy[g]), 32'(po.srrdy));
        if (po.svld) begin
          chk($sformatf("d%0d_sadr", g), s_adr[g], m_adr[po.win]);
          chk($sformatf("d%0d_sdat", g), s_dat[g], m_wd[po.win]);
          chk($sformatf("d%0d_ssel", g), 32'(s_sel[g]),
              32'(m_sel[po.win]));
          chk($sformatf("d%0d_swe", g), 32'(s_we[g]),
              32'(m_we[po.win]));
        end
        for (int m = 0; m < 2; m++) begin
          if (po.rvld[m] || !(ms[g].busy && ms[g].who == m))
            chk($sformatf("d%0d_rdat%0d", g, m), r_dat[g][m],
                po.rdat[m]);
        end
      end
    end
  end

  // Behavioural RAM answering instance 0's handshakes.
  logic [31:0] mem [64];
  int          ram_lat;
  bit          pend;
  int          dly;
  logic [31:0] rdv;
  bit          ga [$];
  bit          gb [$];

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic step();
    bit rq, rs, we;
    logic [31:0] a, wd;
    logic [3:0] sl;
    rq = s_vld[0] & s_qrdy;
    rs = s_rv & s_rrdy[0];
    a  = s_adr[0];
    wd = s_dat[0];
    sl = s_sel[0];
    we = s_we[0];
    if (rq) ga.push_back(q_rdy[0][1]);
    if (s_vld[1] & s_qrdy) gb.push_back(q_rdy[1][1]);
    @(posedge clk);
    #1;
    if (rst) begin
      pend = 0;
      s_rv = 0;
      return;
    end
    if (rs) s_rv = 0;
    if (rq) begin
      if (we)
        for (int b = 0; b < 4; b++)
          if (sl[b]) mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
      rdv  = mem[a[7:2]];
      pend = 1;
      dly  = ram_lat;
    end
    if (pend && !s_rv) begin
      if (dly == 0) begin
        s_rv = 1;
        s_rd = rdv;
        pend = 0;
      end else begin
        dly--;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1; m_adr = '0; m_wd = '0; m_sel = '0; m_we = '0;
    m_vld = '0; m_rrdy = 2'b11; s_qrdy = 1; s_rv = 0; s_rd = '0;
    ram_lat = 0; pend = 0; dly = 0; rdv = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[4] = 32'hCAFE_0010;
    mem[8] = 32'h7777_8888;

    @(posedge clk);
    #1;
    chk_en = 1;
    m_vld = 2'b11;
    nx();
    chk("rst_svld", 32'(s_vld[0]), 0);
    chk("rst_qrdy", 32'(q_rdy[0]), 0);
    step();
    rst = 0;

    // Contention: alternate under RR, m0 always under fixed priority.
    ga.delete(); gb.delete();
    m_adr[0] = 32'h10; m_adr[1] = 32'h20; m_vld = 2'b11;
    repeat (8) begin nx(); step(); end
    m_vld = 2'b00;
    chk("rr_cnt", ga.size(), 4);
    chk("fx_cnt", gb.size(), 4);
    for (int i = 0; i < 4 && i < ga.size(); i++)
      chk($sformatf("rr_g%0d", i), 32'(ga[i]), 32'(i % 2));
    for (int i = 0; i < 4 && i < gb.size(); i++)
      chk($sformatf("fx_g%0d", i), 32'(gb[i]), 0);

    // m0 read alone, first under RAM back-pressure.
    m_adr[0] = 32'h10; m_vld[0] = 1; s_qrdy = 0;
    nx();
    chk("bp_qrdy0", 32'(q_rdy[0][0]), 0);
    chk("bp_svld", 32'(s_vld[0]), 1);
    step();
    s_qrdy = 1;
    nx();
    chk("t1_qrdy0", 32'(q_rdy[0][0]), 1);
    chk("t1_sadr", s_adr[0], 32'h10);
    step();
    m_vld = 0;
    nx();
    chk("t1_rvld0", 32'(r_vld[0][0]), 1);
    chk("t1_rdat0", r_dat[0][0], 32'hCAFE_0010);
    chk("t1_rvld1", 32'(r_vld[0][1]), 0);
    step();

    // m1 partial write then readback via m0.
    m_adr[1] = 32'h20; m_wd[1] = 32'hA5A5_1234;
    m_sel[1] = 4'b0011; m_we[1] = 1; m_vld[1] = 1;
    nx();
    chk("t3_swe", 32'(s_we[0]), 1);
    chk("t3_ssel", 32'(s_sel[0]), 32'h3);
    chk("t3_sdat", s_dat[0], 32'hA5A5_1234);
    step();
    m_vld[1] = 0; m_we[1] = 0;
    nx();
    chk("t3_rvld1", 32'(r_vld[0][1]), 1);
    step();
    m_adr[0] = 32'h20; m_vld[0] = 1;
    nx(); step();
    m_vld[0] = 0;
    nx();
    chk("t3_rb", r_dat[0][0], 32'h7777_1234);
    step();

    // Owner stalls its response for 5 cycles while m1 waits.
    m_rrdy[0] = 0; m_adr[0] = 32'h10; m_vld = 2'b01;
    nx(); step();
    m_vld = 2'b10;
    repeat (5) begin
      nx();
      chk("t4_rvld", 32'(r_vld[0][0]), 1);
      chk("t4_rdat", r_dat[0][0], 32'hCAFE_0010);
      chk("t4_svld", 32'(s_vld[0]), 0);
      chk("t4_err", 32'(r_err[0][0]), 0);
      step();
    end
    m_rrdy[0] = 1;
    nx(); step();
    nx();
    chk("t4_m1gnt", 32'(q_rdy[0][1]), 1);
    step();
    m_vld = 0;
    nx(); step();

    // Watchdog: no response for TMO cycles, then a late drain.
    ram_lat = 6; m_adr[0] = 32'h10; m_vld = 2'b01;
    nx(); step();
    m_vld = 0;
    repeat (TMO) begin
      nx();
      chk("t5_noerr", 32'(r_err[0][0]), 0);
      chk("t5_norsp", 32'(r_vld[0][0]), 0);
      step();
    end
    nx();
    chk("t5_err", 32'(r_err[0][0]), 1);
    chk("t5_evld", 32'(r_vld[0][0]), 1);
    chk("t5_edat", r_dat[0][0], 32'h0);
    step();
    ram_lat = 0; m_vld = 2'b01;
    nx();
    chk("t5_blk0", 32'(s_vld[0]), 0);
    chk("t5_drdy", 32'(s_rrdy[0]), 1);
    step();
    nx();
    chk("t5_blk1", 32'(s_vld[0]), 0);
    chk("t5_disc", 32'(r_vld[0][0]), 0);
    step();
    nx();
    chk("t5_issue", 32'(s_vld[0]), 1);
    step();
    m_vld = 0;
    nx();
    chk("t5_rdat", r_dat[0][0], 32'hCAFE_0010);
    step();

    // Reset while a response is outstanding.
    ram_lat = 3; m_vld = 2'b11;
    nx(); step();
    nx(); step();
    rst = 1;
    repeat (2) begin
      nx();
      chk("t6_svld", 32'(s_vld[0]), 0);
      chk("t6_qrdy", 32'(q_rdy[0]), 0);
      chk("t6_rvld", 32'(r_vld[0]), 0);
      chk("t6_srrdy", 32'(s_rrdy[0]), 0);
      step();
    end
    rst = 0; ram_lat = 0;
    nx();
    chk("t6_m0a", 32'(q_rdy[0]), 32'h1);
    chk("t6_m0b", 32'(q_rdy[1]), 32'h1);
    step();
    m_vld = 0;
    nx(); step();
    nx(); step();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
